// File: rtl/spi_shift.sv
// -----------------------------------------------------------------------------
// spi_shift
//
// Serial data engine that sits directly after spi_clkgen. For each character of
// 1..DATA_WIDTH bits it drives MOSI on clkgen's shift strobes and captures MISO
// on its sample strobes. TIP is fed back to clkgen to gate the serial clock.
// The bit order does not depend on the SPI mode, because clkgen already emits
// its strobes in the order that CPOL/CPHA require.
//
// Ports
//   sys_clk  in   system clock, all state changes on the rising edge
//   rst      in   synchronous reset, active low (0 = reset)
//   go       in   start request, accepted only while idle
//   len      in   character length, 0 encodes DATA_WIDTH bits
//   lsb      in   1 = LSB first, 0 = MSB first
//   tx_data  in   word to transmit, latched when go is accepted
//   shift    in   clkgen drive strobe (one sys_clk wide)
//   sample   in   clkgen capture strobe (one sys_clk wide)
//   miso     in   serial input
//   TIP      out  transfer in progress
//   mosi     out  serial output (registered)
//   rx_data  out  last received character, zero above its length
//   done     out  one-cycle pulse at the end of a transfer
// -----------------------------------------------------------------------------
module spi_shift #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  lsb,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  shift,
    input  logic                  sample,
    input  logic                  miso,
    output logic                  TIP,
    output logic                  mosi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  done
);

    // Counters are one bit wider than len so that a full DATA_WIDTH character
    // length is representable.
    localparam int            CW       = LEN_WIDTH + 1;
    localparam logic [CW-1:0] FULL_LEN = CW'(DATA_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t                  state,   state_nxt;
    logic [DATA_WIDTH-1:0]   tx_sr,   tx_sr_nxt;
    logic [DATA_WIDTH-1:0]   rx_sr,   rx_sr_nxt;
    logic [CW-1:0]           rx_cnt,  rx_cnt_nxt;
    logic [CW-1:0]           tx_ptr,  tx_ptr_nxt;
    logic [CW-1:0]           nbits,   nbits_nxt;
    logic                    lsb_r,   lsb_nxt;
    logic                    mosi_nxt;
    logic                    done_nxt;
    logic [DATA_WIDTH-1:0]   rx_data_nxt;

    // Register bit position for serial position pos of an n-bit character.
    // pos is always below n, so the result fits in LEN_WIDTH bits.
    function automatic logic [LEN_WIDTH-1:0] bit_idx(
        input logic [CW-1:0] pos,
        input logic [CW-1:0] n,
        input logic          lsb_first
    );
        return LEN_WIDTH'(lsb_first ? pos : (n - pos - 1'b1));
    endfunction

    // Advance the transmit pointer but never past the last bit of the
    // character.
    function automatic logic [CW-1:0] sat_inc(
        input logic [CW-1:0] pos,
        input logic [CW-1:0] n
    );
        return ((pos + 1'b1) < n) ? (pos + 1'b1) : pos;
    endfunction

    assign TIP = (state == XFER);

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state   <= IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_cnt  <= '0;
            tx_ptr  <= '0;
            nbits   <= '0;
            lsb_r   <= 1'b0;
            mosi    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            state   <= state_nxt;
            tx_sr   <= tx_sr_nxt;
            rx_sr   <= rx_sr_nxt;
            rx_cnt  <= rx_cnt_nxt;
            tx_ptr  <= tx_ptr_nxt;
            nbits   <= nbits_nxt;
            lsb_r   <= lsb_nxt;
            mosi    <= mosi_nxt;
            done    <= done_nxt;
            rx_data <= rx_data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_sr_nxt   = tx_sr;
        rx_sr_nxt   = rx_sr;
        rx_cnt_nxt  = rx_cnt;
        tx_ptr_nxt  = tx_ptr;
        nbits_nxt   = nbits;
        lsb_nxt     = lsb_r;
        done_nxt    = 1'b0;
        rx_data_nxt = rx_data;

        case (state)
            IDLE: begin
                // Strobes are ignored here; only go matters.
                if (go) begin
                    state_nxt  = XFER;
                    tx_sr_nxt  = tx_data;
                    nbits_nxt  = (len == '0) ? FULL_LEN : {1'b0, len};
                    lsb_nxt    = lsb;
                    rx_sr_nxt  = '0;
                    rx_cnt_nxt = '0;
                    tx_ptr_nxt = '0;
                end
            end

            XFER: begin
                // A shift only advances once the current bit has been
                // sampled. This drops the leading CPHA=1 shift and keeps the
                // trailing CPHA=0 shift, with no mode input needed. The
                // decision uses the pre-update rx_cnt even if a sample
                // arrives in the same cycle.
                if (shift && (rx_cnt > tx_ptr)) begin
                    tx_ptr_nxt = sat_inc(tx_ptr, nbits);
                end

                if (sample) begin
                    rx_sr_nxt[bit_idx(rx_cnt, nbits, lsb_r)] = miso;
                    rx_cnt_nxt = rx_cnt + 1'b1;
                    // Final sample: publish the character including the bit
                    // captured this cycle.
                    if (rx_cnt_nxt == nbits) begin
                        state_nxt   = IDLE;
                        done_nxt    = 1'b1;
                        rx_data_nxt = rx_sr_nxt;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // mosi is registered from the next-state view so the first bit is
        // already on the line in the first XFER cycle, ahead of any strobe.
        if (state_nxt == XFER) begin
            mosi_nxt = tx_sr_nxt[bit_idx(tx_ptr_nxt, nbits_nxt, lsb_nxt)];
        end else begin
            mosi_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_shift.sv
module tb_spi_shift;
    timeunit 1ns;
    timeprecision 1ps;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        go;
    logic [4:0]  len;
    logic        lsb;
    logic [31:0] tx_data;
    logic        shift;
    logic        sample;
    logic        miso;
    logic        TIP;
    logic        mosi;
    logic [31:0] rx_data;
    logic        done;

    always #5 sys_clk = ~sys_clk;

    spi_shift #(.DATA_WIDTH(32), .LEN_WIDTH(5)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .go      (go),
        .len     (len),
        .lsb     (lsb),
        .tx_data (tx_data),
        .shift   (shift),
        .sample  (sample),
        .miso    (miso),
        .TIP     (TIP),
        .mosi    (mosi),
        .rx_data (rx_data),
        .done    (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Observations of the most recent transfer and the model's expectations.
    logic [31:0] obs_seq, exp_seq, exp_rx, end_rx;
    logic        obs_tip_start, obs_mosi0, end_tip, end_done, end_mosi;
    int          bad_cycles;

    function automatic int nbits_of(input logic [4:0] l);
        return (l == 5'd0) ? 32 : int'(l);
    endfunction

    // Serial position p of an n-bit character maps to this register bit.
    function automatic int pos_idx(input int n, input bit lb, input int p);
        return lb ? p : (n - 1 - p);
    endfunction

    task automatic step(input bit sh, input bit sa, input bit chk);
        shift  = sh;
        sample = sa;
        @(posedge sys_clk); #1;
        shift  = 1'b0;
        sample = 1'b0;
        if (chk && (TIP !== 1'b1 || done !== 1'b0)) bad_cycles++;
    endtask

    task automatic idle_gap();
        int g;
        g = $urandom_range(0, 2);
        repeat (g) step(1'b0, 1'b0, 1'b1);
    endtask

    // Runs one character. mode1=0: sample then shift per bit (CPHA=0 order);
    // mode1=1: shift then sample (CPHA=1 order). mmode 0 = loopback,
    // 1 = inverted, 2 = random miso. abort_at/go_mid_at < 0 disable those.
    task automatic xfer(input logic [4:0] l, input bit lb, input logic [31:0] tx,
                        input bit mode1, input int mmode,
                        input int abort_at, input int go_mid_at);
        int   n;
        logic m;
        n          = nbits_of(l);
        exp_rx     = '0;
        exp_seq    = '0;
        obs_seq    = '0;
        bad_cycles = 0;
        for (int i = 0; i < n; i++) exp_seq[i] = tx[pos_idx(n, lb, i)];
        go      = 1'b1;
        len     = l;
        lsb     = lb;
        tx_data = tx;
        @(posedge sys_clk); #1;
        go      = 1'b0;
        len     = 5'($urandom);
        lsb     = 1'($urandom);
        tx_data = $urandom;
        obs_tip_start = TIP;
        obs_mosi0     = mosi;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst = 1'b0;
                @(posedge sys_clk); #1;
                rst = 1'b1;
                return;
            end
            if (i == go_mid_at) begin
                go      = 1'b1;
                tx_data = 32'hFF;
                len     = 5'd1;
                step(1'b0, 1'b0, 1'b1);
                go      = 1'b0;
            end
            case (mmode)
                0:       m = exp_seq[i];
                1:       m = ~exp_seq[i];
                default: m = 1'($urandom);
            endcase
            if (mode1) begin
                idle_gap();
                step(1'b1, 1'b0, 1'b1);
            end
            idle_gap();
            obs_seq[i] = mosi;
            miso = m;
            exp_rx[pos_idx(n, lb, i)] = m;
            step(1'b0, 1'b1, 1'b0);
            if (i < n - 1) begin
                if (TIP !== 1'b1 || done !== 1'b0) bad_cycles++;
                if (!mode1) begin
                    idle_gap();
                    step(1'b1, 1'b0, 1'b1);
                end
            end
        end
        end_tip  = TIP;
        end_done = done;
        end_mosi = mosi;
        end_rx   = rx_data;
    endtask

    task automatic test_reset();
        rst = 1'b0; go = 1'b0; shift = 1'b0; sample = 1'b0; miso = 1'b0;
        len = '0; lsb = 1'b0; tx_data = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        n_tests++; if (TIP !== 1'b0) begin n_fail++; $display("FAIL reset_tip got=%b exp=0", TIP); end
        n_tests++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_tests++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_rx got=%h exp=0", rx_data); end
        rst = 1'b1;
        miso = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_tests++; if (TIP !== 1'b0) begin n_fail++; $display("FAIL idle_strobe_tip got=%b exp=0", TIP); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL idle_strobe_done got=%b exp=0", done); end
        n_tests++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL idle_strobe_rx got=%h exp=0", rx_data); end
    endtask

    task automatic test_mode0();
        step(1'b0, 1'b0, 1'b0);
        xfer(5'd8, 1'b0, 32'hA5, 1'b0, 0, -1, -1);
        n_tests++; if (obs_tip_start !== 1'b1) begin n_fail++; $display("FAIL m0_tip_start got=%b exp=1", obs_tip_start); end
        n_tests++; if (obs_mosi0 !== 1'b1) begin n_fail++; $display("FAIL m0_first_bit got=%b exp=1", obs_mosi0); end
        n_tests++; if (obs_seq !== 32'h000000A5) begin n_fail++; $display("FAIL m0_mosi_seq got=%h exp=000000a5", obs_seq); end
        n_tests++; if (bad_cycles !== 0) begin n_fail++; $display("FAIL m0_tip_window got=%0d exp=0", bad_cycles); end
        n_tests++; if (end_tip !== 1'b0 || end_done !== 1'b1 || end_mosi !== 1'b0) begin
            n_fail++; $display("FAIL m0_end got=tip%b/done%b/mosi%b exp=0/1/0", end_tip, end_done, end_mosi); end
        n_tests++; if (end_rx !== 32'h000000A5) begin n_fail++; $display("FAIL m0_rx got=%h exp=000000a5", end_rx); end
        step(1'b0, 1'b0, 1'b0);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL m0_done_once got=%b exp=0", done); end
        n_tests++; if (rx_data !== 32'h000000A5) begin n_fail++; $display("FAIL m0_rx_hold got=%h exp=000000a5", rx_data); end
    endtask

    task automatic test_mode1();
        step(1'b0, 1'b0, 1'b0);
        xfer(5'd8, 1'b1, 32'h3C, 1'b1, 1, -1, -1);
        n_tests++; if (obs_seq !== 32'h0000003C) begin n_fail++; $display("FAIL m1_mosi_seq got=%h exp=0000003c", obs_seq); end
        n_tests++; if (bad_cycles !== 0) begin n_fail++; $display("FAIL m1_tip_window got=%0d exp=0", bad_cycles); end
        n_tests++; if (end_done !== 1'b1 || end_tip !== 1'b0) begin
            n_fail++; $display("FAIL m1_end got=done%b/tip%b exp=1/0", end_done, end_tip); end
        n_tests++; if (end_rx !== 32'h000000C3) begin n_fail++; $display("FAIL m1_rx got=%h exp=000000c3", end_rx); end
    endtask

    task automatic test_full_len();
        step(1'b0, 1'b0, 1'b0);
        xfer(5'd0, 1'b0, 32'hDEADBEEF, 1'b0, 0, -1, -1);
        n_tests++; if (obs_seq !== exp_seq) begin n_fail++; $display("FAIL full_mosi_seq got=%h exp=%h", obs_seq, exp_seq); end
        n_tests++; if (end_rx !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_rx got=%h exp=deadbeef", end_rx); end
        n_tests++; if (end_done !== 1'b1 || bad_cycles !== 0) begin
            n_fail++; $display("FAIL full_done got=done%b/bad%0d exp=1/0", end_done, bad_cycles); end
        // trailing shift edge arriving in the done cycle
        step(1'b1, 1'b0, 1'b0);
        n_tests++; if (mosi !== 1'b0 || TIP !== 1'b0) begin
            n_fail++; $display("FAIL full_trailing got=mosi%b/tip%b exp=0/0", mosi, TIP); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL full_done_once got=%b exp=0", done); end
    endtask

    task automatic test_go_mid();
        step(1'b0, 1'b0, 1'b0);
        xfer(5'd8, 1'b0, 32'h5A, 1'b0, 0, -1, 4);
        n_tests++; if (obs_seq !== exp_seq) begin n_fail++; $display("FAIL gomid_mosi_seq got=%h exp=%h", obs_seq, exp_seq); end
        n_tests++; if (end_rx !== 32'h0000005A) begin n_fail++; $display("FAIL gomid_rx got=%h exp=0000005a", end_rx); end
        n_tests++; if (bad_cycles !== 0 || end_done !== 1'b1) begin
            n_fail++; $display("FAIL gomid_done got=bad%0d/done%b exp=0/1", bad_cycles, end_done); end
        step(1'b0, 1'b0, 1'b0);
        n_tests++; if (done !== 1'b0 || TIP !== 1'b0) begin
            n_fail++; $display("FAIL gomid_after got=done%b/tip%b exp=0/0", done, TIP); end
    endtask

    task automatic test_mid_reset();
        step(1'b0, 1'b0, 1'b0);
        xfer(5'd8, 1'b0, 32'h96, 1'b0, 0, 3, -1);
        n_tests++; if (TIP !== 1'b0 || mosi !== 1'b0) begin
            n_fail++; $display("FAIL abort_lines got=tip%b/mosi%b exp=0/0", TIP, mosi); end
        n_tests++; if (rx_data !== 32'h0) begin n_fail++; $display("FAIL abort_rx got=%h exp=0", rx_data); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_tests++; if (done !== 1'b0 || TIP !== 1'b0) begin
            n_fail++; $display("FAIL abort_after got=done%b/tip%b exp=0/0", done, TIP); end
        xfer(5'd4, 1'b0, 32'h9, 1'b0, 0, -1, -1);
        n_tests++; if (end_rx !== 32'h9 || end_done !== 1'b1) begin
            n_fail++; $display("FAIL abort_next got=rx%h/done%b exp=00000009/1", end_rx, end_done); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, rx1;
        logic        t1, d1;
        step(1'b0, 1'b0, 1'b0);
        xfer(5'd8, 1'b1, 32'h81, 1'b1, 2, -1, -1);
        r1 = exp_rx; rx1 = end_rx; t1 = end_tip; d1 = end_done;
        xfer(5'd16, 1'b0, 32'h1234BEEF, 1'b0, 0, -1, -1);
        n_tests++; if (rx1 !== r1) begin n_fail++; $display("FAIL b2b_rx1 got=%h exp=%h", rx1, r1); end
        n_tests++; if (t1 !== 1'b0 || d1 !== 1'b1) begin
            n_fail++; $display("FAIL b2b_gap got=tip%b/done%b exp=0/1", t1, d1); end
        n_tests++; if (obs_tip_start !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got=%b exp=1", obs_tip_start); end
        n_tests++; if (end_rx !== 32'h0000BEEF) begin n_fail++; $display("FAIL b2b_rx2 got=%h exp=0000beef", end_rx); end
    endtask

    task automatic test_random();
        logic [4:0]  l;
        logic [31:0] tx;
        bit          lb, m1;
        for (int k = 0; k < 24; k++) begin
            l  = 5'($urandom);
            lb = 1'($urandom);
            m1 = 1'($urandom);
            tx = $urandom;
            if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b0);
            xfer(l, lb, tx, m1, int'($urandom_range(0, 2)), -1, -1);
            n_tests++; if (obs_tip_start !== 1'b1 || obs_mosi0 !== exp_seq[0]) begin
                n_fail++; $display("FAIL rnd%0d_start got=tip%b/mosi%b exp=1/%b", k, obs_tip_start, obs_mosi0, exp_seq[0]); end
            n_tests++; if (obs_seq !== exp_seq) begin
                n_fail++; $display("FAIL rnd%0d_mosi_seq got=%h exp=%h", k, obs_seq, exp_seq); end
            n_tests++; if (bad_cycles !== 0) begin
                n_fail++; $display("FAIL rnd%0d_tip_window got=%0d exp=0", k, bad_cycles); end
            n_tests++; if (end_tip !== 1'b0 || end_done !== 1'b1 || end_mosi !== 1'b0) begin
                n_fail++; $display("FAIL rnd%0d_end got=tip%b/done%b/mosi%b exp=0/1/0", k, end_tip, end_done, end_mosi); end
            n_tests++; if (end_rx !== exp_rx) begin
                n_fail++; $display("FAIL rnd%0d_rx got=%h exp=%h", k, end_rx, exp_rx); end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_full_len();
        test_go_mid();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
